// File: rtl/combo_pkg.sv
// Shared types and helpers for the combo tracker scoring path.
package combo_pkg;

   // Width of the score-multiplier field (tiers 1..7).
   localparam int MULT_W = 3;

   // The single event applied in a cycle after priority resolution.
   typedef enum logic [1:0] {
      EV_NONE,
      EV_HIT,
      EV_FULL,
      EV_MISS
   } combo_event_t;

   // Unsigned add that clamps to 2^width-1 instead of wrapping.
   // The sum carries one extra bit, so no overflow can slip past the clamp.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          width);
      logic [32:0] sum;
      logic [32:0] max_val;
      sum     = {1'b0, a} + {1'b0, b};
      max_val = (33'd1 << width) - 33'd1;
      if (sum > max_val) begin
         return max_val[31:0];
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/combo_tracker_if.sv
// Bus between the hit/miss classifier, the combo tracker and the score accumulator.
interface combo_tracker_if
   import combo_pkg::*;
#(
   parameter int COUNT_W = 7
);
   logic                miss;
   logic                non_full_clear_hit;
   logic                full_clear_hit;
   logic [COUNT_W-1:0]  combo_count;
   logic [COUNT_W-1:0]  best_combo;
   logic [MULT_W-1:0]   multiplier;
   logic                combo_break;

   // Classifier side: drives the level inputs, observes the combo state.
   modport master (
      output miss,
      output non_full_clear_hit,
      output full_clear_hit,
      input  combo_count,
      input  best_combo,
      input  multiplier,
      input  combo_break
   );

   // Tracker side.
   modport slave (
      input  miss,
      input  non_full_clear_hit,
      input  full_clear_hit,
      output combo_count,
      output best_combo,
      output multiplier,
      output combo_break
   );
endinterface

// File: rtl/combo_tier_decode.sv
// Comparator bank mapping a combo count to a score-multiplier tier.
module combo_tier_decode
   import combo_pkg::*;
#(
   parameter int COUNT_W   = 7,
   parameter int TIER_STEP = 5,
   parameter int MAX_TIER  = 4
) (
   input  logic [COUNT_W-1:0] count_i,
   output logic [MULT_W-1:0]  multiplier_o
);

   // Bit k set when count has reached tier threshold k*TIER_STEP.
   // Bit 0 is the base tier and is always reached.
   logic [MAX_TIER-1:0] tier_reached;
   logic [MULT_W-1:0]   tier_count;

   assign tier_reached[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < MAX_TIER; gi++) begin : gen_tier
         assign tier_reached[gi] = (32'(count_i) >= 32'(gi * TIER_STEP));
      end
   endgenerate

   // Multiplier is the number of thresholds reached, clamped to the ceiling.
   always_comb begin
      tier_count = '0;
      for (int i = 0; i < MAX_TIER; i++) begin
         tier_count = tier_count + MULT_W'(tier_reached[i]);
      end
      multiplier_o = (tier_count > MULT_W'(MAX_TIER)) ? MULT_W'(MAX_TIER) : tier_count;
   end

endmodule

// File: rtl/combo_tracker.sv
// Combo tracker: edge-detects classifier levels, resolves one event per cycle,
// and maintains a saturating combo, session best, multiplier tier and
// optional inactivity timeout.
module combo_tracker
   import combo_pkg::*;
#(
   parameter int COUNT_W          = 7,
   parameter int HIT_STEP         = 1,
   parameter int FULL_CLEAR_BONUS = 2,
   parameter int TIER_STEP        = 5,
   parameter int MAX_TIER         = 4,
   parameter int TIMEOUT_CYCLES   = 0
) (
   input  logic            clk,
   input  logic            reset,
   combo_tracker_if.slave  bus
);

   logic                miss_prev_q;
   logic                full_prev_q;
   logic                hit_prev_q;
   logic                miss_edge;
   logic                full_edge;
   logic                hit_edge;
   combo_event_t        ev;

   logic [COUNT_W-1:0]  count_q, count_d;
   logic [COUNT_W-1:0]  best_q,  best_d;
   logic [MULT_W-1:0]   mult_q,  mult_d;
   logic                break_q, break_d;
   logic                timeout_expire;

   // Previous-sample registers; during reset they track the inputs so a level
   // held across reset release is not seen as a new event.
   always_ff @(posedge clk) begin
      miss_prev_q <= bus.miss;
      full_prev_q <= bus.full_clear_hit;
      hit_prev_q  <= bus.non_full_clear_hit;
   end

   assign miss_edge = bus.miss               & ~miss_prev_q;
   assign full_edge = bus.full_clear_hit     & ~full_prev_q;
   assign hit_edge  = bus.non_full_clear_hit & ~hit_prev_q;

   // Priority encode: miss beats full-clear beats ordinary hit; one event only.
   always_comb begin
      ev = EV_NONE;
      if (miss_edge) begin
         ev = EV_MISS;
      end else if (full_edge) begin
         ev = EV_FULL;
      end else if (hit_edge) begin
         ev = EV_HIT;
      end
   end

   // Idle timer exists only when a timeout is configured.
   generate
      if (TIMEOUT_CYCLES > 0) begin : gen_timer
         localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
         logic [IDLE_W-1:0] idle_q, idle_d;

         // Count quiet cycles while a combo is live; flag expiry instead of
         // reaching the limit so the counter clears on the same edge.
         always_comb begin
            idle_d         = '0;
            timeout_expire = 1'b0;
            if (ev == EV_NONE && count_q != '0) begin
               if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_expire = 1'b1;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
         end

         // Idle counter register.
         always_ff @(posedge clk) begin
            if (reset) begin
               idle_q <= '0;
            end else begin
               idle_q <= idle_d;
            end
         end
      end else begin : gen_no_timer
         assign timeout_expire = 1'b0;
      end
   endgenerate

   // Next combo value and break pulse for the resolved event.
   always_comb begin
      count_d = count_q;
      break_d = 1'b0;
      case (ev)
         EV_MISS: begin
            count_d = '0;
            break_d = (count_q != '0);
         end
         EV_FULL: begin
            count_d = COUNT_W'(sat_add(32'(count_q), 32'(FULL_CLEAR_BONUS), COUNT_W));
         end
         EV_HIT: begin
            count_d = COUNT_W'(sat_add(32'(count_q), 32'(HIT_STEP), COUNT_W));
         end
         default: begin
            if (timeout_expire) begin
               count_d = '0;
               break_d = 1'b1;
            end
         end
      endcase
   end

   // Session best follows the next count upward only.
   always_comb begin
      best_d = (count_d > best_q) ? count_d : best_q;
   end

   // Tier is decoded from the next count so it lands on the same edge.
   combo_tier_decode #(
      .COUNT_W   (COUNT_W),
      .TIER_STEP (TIER_STEP),
      .MAX_TIER  (MAX_TIER)
   ) u_tier (
      .count_i      (count_d),
      .multiplier_o (mult_d)
   );

   // Output state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         best_q  <= '0;
         mult_q  <= MULT_W'(1);
         break_q <= 1'b0;
      end else begin
         count_q <= count_d;
         best_q  <= best_d;
         mult_q  <= mult_d;
         break_q <= break_d;
      end
   end

   assign bus.combo_count = count_q;
   assign bus.best_combo  = best_q;
   assign bus.multiplier  = mult_q;
   assign bus.combo_break = break_q;

endmodule

// File: tb/tb_combo_tracker.sv
// Directed bench for combo_tracker with a 50-cycle timeout.
module tb_combo_tracker;
   import combo_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   combo_tracker_if #(.COUNT_W(7)) bus ();

   combo_tracker #(
      .COUNT_W          (7),
      .HIT_STEP         (1),
      .FULL_CLEAR_BONUS (2),
      .TIER_STEP        (5),
      .MAX_TIER         (4),
      .TIMEOUT_CYCLES   (50)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic       m;
      logic       f;
      logic       h;
      logic [6:0] cnt;
      logic [6:0] best;
      logic [2:0] mult;
      logic       brk;
   } vec_t;

   vec_t vecs [20];

   // Drive one cycle of inputs at the falling edge; return just after the rising edge.
   task automatic step(input logic r, input logic m, input logic f, input logic h);
      @(negedge clk);
      reset                  = r;
      bus.miss               = m;
      bus.full_clear_hit     = f;
      bus.non_full_clear_hit = h;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [6:0] cnt, input logic [6:0] best,
                        input logic [2:0] mult, input logic brk);
      n_checks++;
      if (bus.combo_count !== cnt || bus.best_combo !== best ||
          bus.multiplier !== mult || bus.combo_break !== brk) begin
         n_fail++;
         $display("FAIL %s: got count=%0d best=%0d mult=%0d break=%0b, required count=%0d best=%0d mult=%0d break=%0b",
                  name, bus.combo_count, bus.best_combo, bus.multiplier, bus.combo_break,
                  cnt, best, mult, brk);
      end else begin
         $display("ok   %s: count=%0d best=%0d mult=%0d break=%0b",
                  name, bus.combo_count, bus.best_combo, bus.multiplier, bus.combo_break);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset                  = 1'b1;
      bus.miss               = 1'b0;
      bus.full_clear_hit     = 1'b0;
      bus.non_full_clear_hit = 1'b0;

      //            m     f     h     cnt     best    mult  brk
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 7'd1,   7'd1,   3'd1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'd1,   7'd1,   3'd1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 7'd2,   7'd2,   3'd1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 7'd2,   7'd2,   3'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 7'd4,   7'd4,   3'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'd4,   7'd4,   3'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 7'd6,   7'd6,   3'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'd6,   7'd6,   3'd2, 1'b0};
      // full-clear held three cycles: counts once
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 7'd8,   7'd8,   3'd2, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'd8,   7'd8,   3'd2, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 7'd8,   7'd8,   3'd2, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 7'd8,   7'd8,   3'd2, 1'b0};
      // miss together with full-clear: miss wins, break pulses once
      vecs[12] = '{1'b1, 1'b1, 1'b0, 7'd0,   7'd8,   3'd1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd8,   3'd1, 1'b0};
      // full-clear with ordinary hit: only +2
      vecs[14] = '{1'b0, 1'b1, 1'b1, 7'd2,   7'd8,   3'd1, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 7'd2,   7'd8,   3'd1, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd8,   3'd1, 1'b1};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd8,   3'd1, 1'b0};
      // miss at zero: no break
      vecs[18] = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd8,   3'd1, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd8,   3'd1, 1'b0};

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_state", 7'd0, 7'd0, 3'd1, 1'b0);

      // Table vectors
      for (int i = 0; i < 20; i++) begin
         step(1'b0, vecs[i].m, vecs[i].f, vecs[i].h);
         check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].best, vecs[i].mult, vecs[i].brk);
      end

      // Saturation: 63 full-clear pulses to 126, then hits at the ceiling
      for (int i = 0; i < 63; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("sat_126", 7'd126, 7'd126, 3'd4, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("sat_127", 7'd127, 7'd127, 3'd4, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("sat_hold", 7'd127, 7'd127, 3'd4, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("sat_miss", 7'd0, 7'd127, 3'd1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_miss_end", 7'd0, 7'd127, 3'd1, 1'b0);

      // Timeout: combo 3, then 50 idle clocks
      for (int i = 0; i < 3; i++) begin
         if (i != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("to_build3", 7'd3, 7'd127, 3'd1, 1'b0);
      for (int n = 1; n <= 50; n++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (n < 50) check($sformatf("to_idle%0d", n), 7'd3, 7'd127, 3'd1, 1'b0);
         else        check("to_expire", 7'd0, 7'd127, 3'd1, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("to_after", 7'd0, 7'd127, 3'd1, 1'b0);

      // Hit in the expiry cycle wins
      for (int i = 0; i < 3; i++) begin
         if (i != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("exp_build3", 7'd3, 7'd127, 3'd1, 1'b0);
      for (int n = 1; n <= 49; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("exp_idle49", 7'd3, 7'd127, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("exp_hit_wins", 7'd4, 7'd127, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("exp_hit_next", 7'd4, 7'd127, 3'd1, 1'b0);

      // Hit level held across reset release: no event
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("rst_hold_in", 7'd0, 7'd0, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_hold_rel", 7'd0, 7'd0, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_hold_low", 7'd0, 7'd0, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_hold_new", 7'd1, 7'd1, 3'd1, 1'b0);

      // Reset at combo 9
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      check("mid_build9", 7'd9, 7'd9, 3'd2, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_reset", 7'd0, 7'd0, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_reset_rel", 7'd0, 7'd0, 3'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
